// File: rtl/ams_pwm_dac_if.sv
// ams_pwm_dac_if -- channel bus between the AMS register block and one PWM DAC.
//   cfg_i   : 24-bit DAC word {base[7:0], dither[15:0]} from the register block
//   pwm_o   : registered one-bit PWM stream to the pad
//   frame_o : one-cycle pulse marking the first pwm_o sample of each 16-period frame
// master = register-block side (drives cfg_i), slave = the DAC (drives pwm_o/frame_o).
interface ams_pwm_dac_if;
  logic [23:0] cfg_i;
  logic        pwm_o;
  logic        frame_o;

  modport master (output cfg_i, input pwm_o, input frame_o);
  modport slave  (input cfg_i, output pwm_o, output frame_o);
endinterface

// File: rtl/ams_pwm_dac.sv
// ams_pwm_dac -- dithered PWM DAC, one instance per analog channel.
//   Each 24-bit word = 8-bit base high count + 16-bit dither sequence. Every
//   period is FULL cycles long; period k of a 16-period frame is high for
//   base + dither[k] cycles (saturating at FULL), giving sub-LSB average
//   resolution after the external RC filter.
// Ports:
//   clk_i  : ADC-domain clock (cfg_i is already in this domain)
//   rstn_i : asynchronous active-low reset
//   bus    : ams_pwm_dac_if.slave {cfg_i in, pwm_o out, frame_o out}
// Parameter FULL: period length in clk_i cycles, 2..255 (8-bit counter).
module ams_pwm_dac #(
  parameter int unsigned FULL = 156
) (
  input logic          clk_i,
  input logic          rstn_i,
  ams_pwm_dac_if.slave bus
);

  localparam logic [7:0] LAST = 8'(FULL - 1);

  logic [7:0]  vcnt;     // position within the period
  logic [3:0]  bcnt;     // period index within the frame
  logic [7:0]  base_s;   // shadow of cfg_i[23:16]
  logic [15:0] seq_s;    // shadow of cfg_i[15:0]
  logic [8:0]  thr;      // high count for the current period, 0..256
  logic        pwm_q;
  logic        frame_q;
  logic        period_end;
  logic        frame_end;

  assign period_end = (vcnt == LAST);
  assign frame_end  = period_end && (bcnt == 4'hF);

  // Nine bits so base 255 plus a dither bit cannot wrap; any thr >= FULL
  // simply keeps the compare true for the whole period.
  assign thr = {1'b0, base_s} + {8'd0, seq_s[bcnt]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vcnt    <= '0;
      bcnt    <= '0;
      base_s  <= '0;
      seq_s   <= '0;
      pwm_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      vcnt <= period_end ? 8'd0 : vcnt + 8'd1;
      if (period_end) bcnt <= bcnt + 4'd1;

      // Capture only at the frame boundary so a word never tears a frame;
      // the new value first drives pwm_q on the following edge.
      if (frame_end) begin
        base_s <= bus.cfg_i[23:16];
        seq_s  <= bus.cfg_i[15:0];
      end

      pwm_q   <= ({1'b0, vcnt} < thr);
      frame_q <= (vcnt == 8'd0) && (bcnt == 4'd0);
    end
  end

  assign bus.pwm_o   = pwm_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_ams_pwm_dac.sv
// tb_ams_pwm_dac -- self-checking bench for ams_pwm_dac (FULL = 156).
//   Table of DAC words with hand-computed per-period high counts; each word's
//   expectation is pushed to a scoreboard queue when the word is driven and
//   popped when the DUT emits the corresponding frame. Hand-written sequences
//   cover reset/first frame, mid-frame updates and asynchronous reset.
module tb_ams_pwm_dac;
  localparam int FULL  = 156;
  localparam int FRAME = 16 * FULL;

  logic clk_i = 1'b0;
  logic rstn_i;
  ams_pwm_dac_if bus ();

  ams_pwm_dac #(.FULL(FULL)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [23:0] cfg;
    int          hi_base;   // high cycles in a period whose dither bit is 0
    int          hi_dith;   // high cycles in a period whose dither bit is 1
    int          total;     // high cycles over the frame
  } vec_t;

  vec_t vecs[10];
  vec_t sb[$];

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [23:0] c,
                              input int hb, input int hd, input int t);
    vec_t v;
    v.name = n; v.cfg = c; v.hi_base = hb; v.hi_dith = hd; v.total = t;
    return v;
  endfunction

  // Wait for the next frame pulse, then sample one whole frame. With mid_upd
  // set, cfg_i is rewritten while the DUT is in period 5 and period 9.
  task automatic measure_frame(input bit mid_upd);
    int   wait_n = 0;
    int   hi[16];
    int   frames = 0;
    int   tot = 0;
    bit   shape = 1'b1;
    bit   low_seen;
    vec_t e;
    do begin
      @(negedge clk_i);
      wait_n++;
    end while (!bus.frame_o && wait_n < 2 * FRAME);
    check("frame_gap", wait_n, 1);
    for (int p = 0; p < 16; p++) begin
      hi[p] = 0;
      low_seen = 1'b0;
      for (int c = 0; c < FULL; c++) begin
        if (!(p == 0 && c == 0)) @(negedge clk_i);
        // sample index p*FULL means the DUT counters now sit at bcnt=p
        if (mid_upd && c == 0 && p == 5) bus.cfg_i = 24'h200000;
        if (mid_upd && c == 0 && p == 9) begin
          bus.cfg_i = 24'h400000;
          sb.push_back(mk("mid_0x40", 24'h400000, 64, 65, 1024));
        end
        if (bus.frame_o) frames++;
        if (bus.pwm_o) begin
          hi[p]++;
          tot++;
          if (low_seen) shape = 1'b0;
        end else begin
          low_seen = 1'b1;
        end
      end
    end
    if (sb.size() == 0) begin
      nvec++;
      nmis++;
      $display("FAIL sb_empty: frame arrived with no expectation queued");
    end else begin
      e = sb.pop_front();
      check({e.name, "_frame_pulses"}, frames, 1);
      check({e.name, "_shape"}, int'(shape), 1);
      for (int p = 0; p < 16; p++)
        check($sformatf("%s_p%0d", e.name, p), hi[p],
              e.cfg[p] ? e.hi_dith : e.hi_base);
      check({e.name, "_total"}, tot, e.total);
    end
  endtask

  // Cycles 1..FRAME after release: frame pulse only on cycle 1, pwm all low.
  task automatic check_first_frame(input string tag);
    int highs = 0;
    int extra = 0;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk_i);
      if (k == 1) check({tag, "_frame_c1"}, int'(bus.frame_o), 1);
      else if (bus.frame_o) extra++;
      if (bus.pwm_o) highs++;
    end
    check({tag, "_first_frame_pwm_highs"}, highs, 0);
    check({tag, "_first_frame_extra_pulses"}, extra, 0);
  endtask

  initial begin
    vecs[0] = mk("base_0x4E",   24'h4E0000,  78,  79, 1248);
    vecs[1] = mk("dither_0x10", 24'h100001,  16,  17,  257);
    vecs[2] = mk("all_ones",    24'hFFFFFF, 156, 156, 2496);
    vecs[3] = mk("zero",        24'h000000,   0,   1,    0);
    vecs[4] = mk("0x9BFFFF",    24'h9BFFFF, 155, 156, 2496);
    vecs[5] = mk("0x30A5A5",    24'h30A5A5,  48,  49,  776);
    vecs[6] = mk("0x9C0001",    24'h9C0001, 156, 156, 2496);
    vecs[7] = mk("0x01FFFF",    24'h01FFFF,   1,   2,   32);
    vecs[8] = mk("0x9B0000",    24'h9B0000, 155, 156, 2480);
    vecs[9] = mk("0x00FFFF",    24'h00FFFF,   0,   1,   16);

    // reset state and first frame
    bus.cfg_i = 24'h9C0000;
    rstn_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_pwm", int'(bus.pwm_o), 0);
    check("reset_frame", int'(bus.frame_o), 0);
    sb.push_back(mk("sat_0x9C", 24'h9C0000, 156, 156, 2496));
    rstn_i = 1'b1;
    check_first_frame("por");
    measure_frame(1'b0);   // frame 2, base saturates

    // table: drive at the post-capture point, so each word lands two frames on
    sb.push_back(mk("sat_0x9C_hold", 24'h9C0000, 156, 156, 2496));
    for (int i = 0; i < 10; i++) begin
      bus.cfg_i = vecs[i].cfg;
      sb.push_back(vecs[i]);
      measure_frame(1'b0);
    end

    // mid-frame updates: current frame untouched, only the last word survives
    measure_frame(1'b1);
    measure_frame(1'b0);

    // asynchronous reset while pwm_o is high early in a 64-high period
    repeat (11) @(negedge clk_i);
    check("pre_reset_pwm_high", int'(bus.pwm_o), 1);
    #2 rstn_i = 1'b0;
    #1;
    check("async_reset_pwm", int'(bus.pwm_o), 0);
    check("async_reset_frame", int'(bus.frame_o), 0);
    bus.cfg_i = 24'h9C0000;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    sb.push_back(mk("post_rst_0x9C", 24'h9C0000, 156, 156, 2496));
    check_first_frame("rst2");
    measure_frame(1'b0);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/ams_pwm_dac.md
# ams_pwm_dac

PWM DAC generator that turns each 24-bit DAC word from the analog mixed-signal register block (dac_a_o..dac_d_o) into a one-bit PWM stream for the external RC-filtered analog outputs. One instance per channel sits between the register block and the output pad. It runs in the ADC clock domain, so no synchronisation is needed. Each word is an 8-bit base duty plus a 16-bit dither sequence: the base sets the duty of every PWM period, and each dither bit adds one extra high cycle to one of 16 consecutive periods. This gives sub-LSB average resolution.

## Interface
Parameters
- FULL, 156: PWM period in clk_i cycles; legal range 2..255. The counter is fixed at 8 bits.

Ports
- clk_i  input  1  ADC-domain clock.
- rstn_i  input  1  reset; asynchronous, active-low.
- cfg_i  input  24  DAC word. [23:16] is the base high count; [15:0] is the dither sequence, with bit k used in period k of a frame.
- pwm_o  output  1  registered PWM bit to the pad.
- frame_o  output  1  one-cycle pulse, registered, aligned with the first pwm_o sample of each 16-period frame.

## Operation
- Period counter vcnt, 8 bits: counts 0..FULL-1 and wraps to 0.
- Period index bcnt, 4 bits: increments at each vcnt wrap and wraps 15 -> 0.
  - Period = FULL cycles; frame = 16*FULL cycles (2496 at default).
- Shadow registers base_s (8 bits) and seq_s (16 bits):
  - Load cfg_i only on the edge where vcnt==FULL-1 and bcnt==15 (frame end).
  - cfg_i is ignored at all other times, so a new word never tears a frame.
- Threshold thr, 9 bits, combinational: thr = base_s + seq_s[bcnt].
  - No overflow: the maximum value is 256.
- Output: pwm_o <= (vcnt < thr), an unsigned 9-bit compare with vcnt zero-extended.
  - thr >= FULL: pwm_o is high for the whole period (saturation).
  - thr == 0: pwm_o is low for the whole period.
- Frame marker: frame_o <= (vcnt==0 && bcnt==0).
- Average duty over a frame = (16*min(base,FULL) + popcount(seq), counted only for periods not saturated) / (16*FULL).
- No state machine beyond the two counters. Behaviour is free-running and cannot be stalled.

## Timing
- Reset, asynchronous assert: vcnt=0, bcnt=0, base_s=0, seq_s=0, pwm_o=0, frame_o=0, all immediately without a clock edge.
- Reset release: the first rising edge evaluates vcnt=0, bcnt=0.
  - frame_o is high after that edge.
  - frame_o then pulses every 16*FULL cycles.
- The shadow is zero after reset, so pwm_o stays 0 for the whole first frame regardless of cfg_i.
- Latency from counters to output: 1 cycle. pwm_o reflects the vcnt/bcnt values present before the edge.
- Latency from cfg_i to output:
  - cfg_i is captured on the frame-end edge.
  - The new value appears on pwm_o one edge later, coincident with frame_o=1.
  - Worst case is 16*FULL+1 cycles after a cfg_i change.
- Simultaneous events:
  - A cfg_i change on the capture edge is captured; the setup value at that edge counts.
  - A change one cycle later waits a full frame.
- Reset mid-period: pwm_o drops at once. The count restarts from 0 and the shadow is cleared.

## Test plan
- Reset and first frame, cfg_i=0x9C0000 held:
  - pwm_o=0 for the first 2496 cycles after release.
  - frame_o high on cycles 1 and 2497.
  - From cycle 2497 onward pwm_o is constant 1 (base 156 saturates).
- Base only, cfg_i=0x4E0000, after one frame: every period is 78 cycles high then 78 low, with no jitter across 16 periods.
- Dither, cfg_i=0x100001: period 0 of each frame is 17 high / 139 low; periods 1..15 are 16 high / 140 low; 257 high cycles per frame.
- Saturation and zero:
  - cfg_i=0xFFFFFF gives pwm_o constant 1.
  - cfg_i=0x000000 gives pwm_o constant 0.
  - cfg_i=0x9BFFFF gives every period 156 high (thr=156).
- Mid-frame update:
  - Set cfg_i=0x200000 at bcnt=5, then 0x400000 at bcnt=9, in the same frame.
  - The current frame is unchanged.
  - The next frame uses 0x40 (64 high per period); 0x20 never appears.
- Asynchronous reset with pwm_o=1 in mid-period:
  - pwm_o=0 and frame_o=0 before the next clock edge.
  - After release, the frame_o pulse and counting restart as in the first scenario.
